// File: rtl/server_traffic_gen_if.sv
// ---------------------------------------------------------------------------
// server_traffic_gen_if
// AXI4-Stream style bus carrying generated Ethernet frames, 64-bit beats.
//   tvalid : beat valid               (master -> slave)
//   tdata  : 64-bit beat payload      (master -> slave)
//   tlast  : final beat of the frame  (master -> slave)
//   tkeep  : byte enables             (master -> slave)
//   tuser  : user sideband            (master -> slave)
//   tready : sink can accept a beat   (slave  -> master)
// ---------------------------------------------------------------------------
interface server_traffic_gen_if;
  logic        tvalid;
  logic [63:0] tdata;
  logic        tlast;
  logic [7:0]  tkeep;
  logic        tuser;
  logic        tready;

  modport master (output tvalid, output tdata, output tlast, output tkeep,
                  output tuser, input tready);
  modport slave  (input tvalid, input tdata, input tlast, input tkeep,
                  input tuser, output tready);
endinterface

// File: rtl/server_traffic_gen.sv
// ---------------------------------------------------------------------------
// server_traffic_gen
// Generates Ethernet-like frames towards pseudo-randomly chosen servers.
// Each frame: beat 0 = {dest MAC, src MAC[47:32]}, beat 1 = {src MAC[31:0],
// EtherType 0x0800, 0}, remaining beats = time stamp sampled on load.
// Ports:
//   i_clk, i_rst_n      : clock, synchronous active-low reset
//   i_stat_rx_status    : link up, qualifies the start of a frame
//   i_enable            : generation enable
//   i_pkt_len           : frame length in beats (clamped to >= 3)
//   i_gap_cycles        : idle cycles after each frame (clamped to >= 1)
//   i_pkt_limit         : frames to send, 0 = unlimited
//   i_excl_local        : never target the local ToR
//   i_time_stamp        : payload source
//   m_axis              : AXIS master (tvalid/tdata/tlast/tkeep/tuser/tready)
//   o_pkt_cnt           : completed frames (saturating)
//   o_busy / o_done     : FSM in RANDOM/DATA/GAP, FSM in DONE
// ---------------------------------------------------------------------------
module server_traffic_gen #(
  parameter int          P_UPLINK_TRUE = 0,
  parameter int          P_TOR_NUM     = 8,
  parameter int          P_SERVER_NUM  = 2,
  parameter int          P_MY_TOR_ID   = 0,
  parameter logic [15:0] P_SEED        = 16'hACE1,
  parameter logic [31:0] P_MAC_HEAD    = 32'h8DBC_5C4A,
  parameter logic [47:0] P_MY_PORT_MAC = 48'h8DBC_5C4A_0001
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_stat_rx_status,
  input  logic                        i_enable,
  input  logic [15:0]                 i_pkt_len,
  input  logic [15:0]                 i_gap_cycles,
  input  logic [31:0]                 i_pkt_limit,
  input  logic                        i_excl_local,
  input  logic [63:0]                 i_time_stamp,
  server_traffic_gen_if.master        m_axis,
  output logic [31:0]                 o_pkt_cnt,
  output logic                        o_busy,
  output logic                        o_done
);

  localparam int          TOR_W = $clog2(P_TOR_NUM);
  localparam int          SRV_W = $clog2(P_SERVER_NUM);
  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [15:0] SEED  = (P_SEED == 16'h0000) ? 16'h0001 : P_SEED;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RANDOM = 3'd1,
    ST_DATA   = 3'd2,
    ST_GAP    = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shift left, feedback into bit 0.
  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    logic fb;
    fb = cur[15] ^ cur[13] ^ cur[12] ^ cur[10];
    return {cur[14:0], fb};
  endfunction

  state_t      state_r, state_nxt_s;
  logic [15:0] lfsr_r;
  logic [15:0] len_r, gap_r, beat_r, gap_cnt_r;
  logic [47:0] dest_mac_r;
  logic        tvalid_r, tlast_r;
  logic [63:0] tdata_r;
  logic [31:0] pkt_cnt_r;
  logic        busy_r, done_r;

  logic [7:0]  cand_tor_s, cand_srv_s;
  logic        start_s, reject_s, hs_s, last_hs_s, load_s, gap_end_s, limit_hit_s;
  logic [63:0] beat_data_s;

  // Destination candidate comes from the LFSR value before it advances.
  assign cand_tor_s = 8'(lfsr_r[TOR_W-1:0]);

  if (SRV_W == 0) begin : g_one_srv
    assign cand_srv_s = 8'd1;
  end else begin : g_multi_srv
    assign cand_srv_s = 8'(lfsr_r[8 +: SRV_W]) + 8'd1;
  end

  assign start_s     = i_enable && i_stat_rx_status && (P_UPLINK_TRUE == 0);
  assign reject_s    = i_excl_local && (cand_tor_s == 8'(P_MY_TOR_ID));
  assign hs_s        = tvalid_r && m_axis.tready;
  assign last_hs_s   = (state_r == ST_DATA) && hs_s && tlast_r;
  // Once all beats are loaded beat_r == len_r, so the final handshake can
  // never coincide with loading another beat.
  assign load_s      = (state_r == ST_DATA) && (!tvalid_r || m_axis.tready) &&
                       (beat_r < len_r);
  assign gap_end_s   = (gap_cnt_r == (gap_r - 16'd1));
  assign limit_hit_s = (i_pkt_limit != 32'd0) && (pkt_cnt_r >= i_pkt_limit);

  // Beat payload selection by beat index.
  always_comb begin
    beat_data_s = i_time_stamp;
    case (beat_r)
      16'd0:   beat_data_s = {dest_mac_r, P_MY_PORT_MAC[47:32]};
      16'd1:   beat_data_s = {P_MY_PORT_MAC[31:0], 16'h0800, 16'h0000};
      default: beat_data_s = i_time_stamp;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) state_nxt_s = ST_RANDOM;
        else         state_nxt_s = ST_IDLE;
      end
      ST_RANDOM: begin
        if (reject_s) state_nxt_s = ST_RANDOM;
        else          state_nxt_s = ST_DATA;
      end
      ST_DATA: begin
        if (last_hs_s) state_nxt_s = ST_GAP;
        else           state_nxt_s = ST_DATA;
      end
      ST_GAP: begin
        if (gap_end_s) begin
          if (limit_hit_s) state_nxt_s = ST_DONE;
          else             state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_GAP;
        end
      end
      ST_DONE: begin
        if (!i_enable) state_nxt_s = ST_IDLE;
        else           state_nxt_s = ST_DONE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register, LFSR, frame parameters and AXIS output register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r    <= ST_IDLE;
      lfsr_r     <= SEED;
      len_r      <= 16'd3;
      gap_r      <= 16'd1;
      beat_r     <= 16'd0;
      gap_cnt_r  <= 16'd0;
      dest_mac_r <= 48'd0;
      tvalid_r   <= 1'b0;
      tlast_r    <= 1'b0;
      tdata_r    <= 64'd0;
      pkt_cnt_r  <= 32'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == ST_RANDOM) || (state_nxt_s == ST_DATA) ||
                 (state_nxt_s == ST_GAP);
      done_r  <= (state_nxt_s == ST_DONE);

      if (state_r == ST_RANDOM) begin
        lfsr_r <= lfsr_step(lfsr_r);
      end

      // Frame parameters are frozen for the whole frame at start.
      if ((state_r == ST_IDLE) && start_s) begin
        len_r  <= (i_pkt_len < 16'd3) ? 16'd3 : i_pkt_len;
        gap_r  <= (i_gap_cycles < 16'd1) ? 16'd1 : i_gap_cycles;
        beat_r <= 16'd0;
      end

      if ((state_r == ST_RANDOM) && !reject_s) begin
        dest_mac_r <= {P_MAC_HEAD, cand_tor_s, cand_srv_s};
      end

      if (load_s) begin
        tdata_r  <= beat_data_s;
        tlast_r  <= (beat_r == (len_r - 16'd1));
        tvalid_r <= 1'b1;
        beat_r   <= beat_r + 16'd1;
      end else if (hs_s) begin
        tvalid_r <= 1'b0;
        tlast_r  <= 1'b0;
      end

      if (last_hs_s) begin
        if (pkt_cnt_r != 32'hFFFF_FFFF) pkt_cnt_r <= pkt_cnt_r + 32'd1;
      end else if ((state_r == ST_DONE) && !i_enable) begin
        pkt_cnt_r <= 32'd0;
      end

      if (state_r == ST_GAP) gap_cnt_r <= gap_cnt_r + 16'd1;
      else                   gap_cnt_r <= 16'd0;
    end
  end

  assign m_axis.tvalid = tvalid_r;
  assign m_axis.tdata  = tdata_r;
  assign m_axis.tlast  = tlast_r;
  assign m_axis.tkeep  = 8'hFF;
  assign m_axis.tuser  = 1'b0;
  assign o_pkt_cnt     = pkt_cnt_r;
  assign o_busy        = busy_r;
  assign o_done        = done_r;

endmodule

// File: tb/tb_server_traffic_gen.sv
// ---------------------------------------------------------------------------
// tb_server_traffic_gen
// Directed stimulus with a scoreboard queue of expected beats; a monitor on
// the falling edge pops and compares every handshaken beat and checks that
// stalled beats hold. The DUT uses P_MY_TOR_ID=1, so the basic cases run
// with i_excl_local=0 and the exclusion case with i_excl_local=1.
// ---------------------------------------------------------------------------
module tb_server_traffic_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_status = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] pkt_len = 16'd4;
  logic [15:0] gap_cycles = 16'd2;
  logic [31:0] pkt_limit = 32'd0;
  logic        excl_local = 1'b0;
  logic [63:0] time_stamp = 64'd0;
  logic [31:0] pkt_cnt;
  logic        busy, done;

  server_traffic_gen_if bus ();

  server_traffic_gen #(
    .P_MY_TOR_ID (1),
    .P_SEED      (16'hACE1)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_stat_rx_status (rx_status),
    .i_enable         (enable),
    .i_pkt_len        (pkt_len),
    .i_gap_cycles     (gap_cycles),
    .i_pkt_limit      (pkt_limit),
    .i_excl_local     (excl_local),
    .i_time_stamp     (time_stamp),
    .m_axis           (bus.master),
    .o_pkt_cnt        (pkt_cnt),
    .o_busy           (busy),
    .o_done           (done)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          hs_cnt = 0;
  int          last_cnt = 0;
  logic [64:0] exp_q[$];
  logic        prev_stall = 1'b0;
  logic [64:0] prev_beat = 65'd0;

  task automatic check(input string nm, input logic [65:0] act, input logic [65:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Expected frame towards {tor, srv}; payload beats carry ts.
  task automatic push_pkt(input logic [7:0] tor, input logic [7:0] srv,
                          input int len, input logic [63:0] ts);
    logic [63:0] d;
    logic        lst;
    for (int k = 0; k < len; k++) begin
      if (k == 0)      d = {32'h8DBC5C4A, tor, srv, 16'h8DBC};
      else if (k == 1) d = 64'h5C4A0001_0800_0000;
      else             d = ts;
      lst = (k == len - 1);
      exp_q.push_back({lst, d});
    end
  endtask

  task automatic do_reset();
    enable = 1'b0;
    rst_n  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic wait_pkts(input int n, input int budget, input string nm);
    int c;
    c = 0;
    while ((pkt_cnt < n) && (c < budget)) begin
      @(posedge clk);
      #1;
      c++;
    end
    check(nm, 66'(pkt_cnt >= n), 66'd1);
  endtask

  task automatic first_valid_latency(output int cyc);
    cyc = 0;
    while (!bus.tvalid && (cyc < 50)) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  // Scoreboard monitor: compare every handshaken beat, check stall hold.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_hold", {bus.tvalid, bus.tlast, bus.tdata}, {1'b1, prev_beat});
      end
      if (bus.tvalid && bus.tready) begin
        hs_cnt <= hs_cnt + 1;
        if (bus.tlast) last_cnt <= last_cnt + 1;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_beat: got %h expected no beat", bus.tdata);
        end else begin
          logic [64:0] e;
          e = exp_q.pop_front();
          check("beat_data", 66'(bus.tdata), 66'(e[63:0]));
          check("beat_last", 66'(bus.tlast), 66'(e[64]));
        end
      end
      prev_stall <= bus.tvalid && !bus.tready;
      prev_beat  <= {bus.tlast, bus.tdata};
    end
  end

  initial begin
    int lat;
    int base_hs;
    int base_last;
    int c;
    bus.tready = 1'b1;

    // Reset state
    do_reset();
    check("rst_tvalid", 66'(bus.tvalid), 66'd0);
    check("rst_tdata",  66'(bus.tdata),  66'd0);
    check("rst_tlast",  66'(bus.tlast),  66'd0);
    check("rst_pkt_cnt", 66'(pkt_cnt),   66'd0);
    check("rst_busy",   66'(busy),       66'd0);
    check("rst_done",   66'(done),       66'd0);
    check("tkeep",      66'(bus.tkeep),  66'hFF);
    check("tuser",      66'(bus.tuser),  66'd0);

    // Basic frame: len 4, gap 2, dest tor 1 / server 1
    pkt_len    = 16'd4;
    gap_cycles = 16'd2;
    time_stamp = 64'h0123_4567_89AB_CDEF;
    push_pkt(8'd1, 8'd1, 4, time_stamp);
    enable = 1'b1;
    first_valid_latency(lat);
    check("basic_latency", 66'(lat), 66'd3);
    wait_pkts(1, 100, "basic_pkt_wait");
    enable = 1'b0;
    check("gap1_tvalid", 66'(bus.tvalid), 66'd0);
    check("gap1_busy",   66'(busy),       66'd1);
    @(posedge clk); #1;
    check("gap2_tvalid", 66'(bus.tvalid), 66'd0);
    check("gap2_busy",   66'(busy),       66'd1);
    @(posedge clk); #1;
    check("gap_end_busy", 66'(busy),      66'd0);
    check("basic_q_empty", 66'(exp_q.size()), 66'd0);

    // Backpressure: tready toggles every cycle, len 8
    do_reset();
    pkt_len    = 16'd8;
    time_stamp = 64'hDEAD_BEEF_0000_0002;
    push_pkt(8'd1, 8'd1, 8, time_stamp);
    base_hs   = hs_cnt;
    base_last = last_cnt;
    enable = 1'b1;
    c = 0;
    while ((pkt_cnt < 1) && (c < 200)) begin
      @(posedge clk); #1;
      bus.tready = ~bus.tready;
      c++;
    end
    bus.tready = 1'b1;
    enable = 1'b0;
    check("bp_pkt_cnt", 66'(pkt_cnt), 66'd1);
    check("bp_handshakes", 66'(hs_cnt - base_hs), 66'd8);
    check("bp_tlasts", 66'(last_cnt - base_last), 66'd1);
    check("bp_q_empty", 66'(exp_q.size()), 66'd0);

    // Exclusion: first candidate (tor 1) rejected, next is tor 3 / server 2
    do_reset();
    pkt_len    = 16'd3;
    excl_local = 1'b1;
    time_stamp = 64'h0000_0000_0000_0003;
    push_pkt(8'd3, 8'd2, 3, time_stamp);
    enable = 1'b1;
    first_valid_latency(lat);
    check("excl_latency", 66'(lat), 66'd4);
    wait_pkts(1, 100, "excl_pkt_wait");
    enable     = 1'b0;
    excl_local = 1'b0;
    check("excl_q_empty", 66'(exp_q.size()), 66'd0);

    // Packet limit: 3 frames with successive LFSR destinations, then DONE
    do_reset();
    pkt_len    = 16'd3;
    gap_cycles = 16'd1;
    pkt_limit  = 32'd3;
    time_stamp = 64'h4444_5555_6666_7777;
    push_pkt(8'd1, 8'd1, 3, time_stamp);
    push_pkt(8'd3, 8'd2, 3, time_stamp);
    push_pkt(8'd7, 8'd2, 3, time_stamp);
    enable = 1'b1;
    c = 0;
    while (!done && (c < 400)) begin
      @(posedge clk); #1;
      c++;
    end
    check("limit_done", 66'(done), 66'd1);
    check("limit_pkt_cnt", 66'(pkt_cnt), 66'd3);
    check("limit_busy", 66'(busy), 66'd0);
    check("limit_q_empty", 66'(exp_q.size()), 66'd0);
    repeat (5) @(posedge clk);
    #1;
    check("limit_hold_cnt", 66'(pkt_cnt), 66'd3);
    check("limit_hold_tvalid", 66'(bus.tvalid), 66'd0);
    enable = 1'b0;
    @(posedge clk); #1;
    check("done_exit_done", 66'(done), 66'd0);
    check("done_exit_cnt", 66'(pkt_cnt), 66'd0);
    pkt_limit = 32'd0;

    // Length clamp: len 1 becomes a 3-beat frame
    do_reset();
    pkt_len    = 16'd1;
    gap_cycles = 16'd2;
    time_stamp = 64'hAAAA_BBBB_CCCC_DDDD;
    push_pkt(8'd1, 8'd1, 3, time_stamp);
    base_hs   = hs_cnt;
    base_last = last_cnt;
    enable = 1'b1;
    wait_pkts(1, 100, "clamp_pkt_wait");
    enable = 1'b0;
    check("clamp_beats", 66'(hs_cnt - base_hs), 66'd3);
    check("clamp_tlasts", 66'(last_cnt - base_last), 66'd1);
    check("clamp_q_empty", 66'(exp_q.size()), 66'd0);

    // Reset at beat 5 of an 8-beat frame
    do_reset();
    pkt_len    = 16'd8;
    time_stamp = 64'h5555_0000_5555_0000;
    push_pkt(8'd1, 8'd1, 8, time_stamp);
    base_hs   = hs_cnt;
    base_last = last_cnt;
    enable = 1'b1;
    c = 0;
    while (((hs_cnt - base_hs) < 5) && (c < 100)) begin
      @(posedge clk); #1;
      c++;
    end
    check("mid_reach_beat5", 66'(hs_cnt - base_hs), 66'd5);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_tvalid", 66'(bus.tvalid), 66'd0);
    check("mid_rst_pkt_cnt", 66'(pkt_cnt), 66'd0);
    check("mid_rst_no_tlast", 66'(last_cnt - base_last), 66'd0);
    exp_q.delete();
    time_stamp = 64'h6666_0000_6666_0000;
    push_pkt(8'd1, 8'd1, 8, time_stamp);
    rst_n = 1'b1;
    wait_pkts(1, 100, "mid_restart_wait");
    enable = 1'b0;
    check("mid_restart_q_empty", 66'(exp_q.size()), 66'd0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
